// File: rtl/counter_pkg.sv
// Shared constants for the parametrised up/down counter family.
// Direction and boundary-mode encodings plus default sizing.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  localparam int CNT_DEFAULT_WIDTH      = 8;
  localparam int CNT_DEFAULT_PRESCALE_W = 4;

endpackage

// File: rtl/prescaler_tick.sv
// Clock-enable prescaler: emits step once every prescale+1 enabled cycles.
// The phase freezes while enable is low and restarts from 0 on clear.
// A phase already above a newly lowered prescale runs to its natural wrap.
module prescaler_tick
  import counter_pkg::*;
#(
  parameter int PRESCALE_W = CNT_DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  step
);

  logic [PRESCALE_W-1:0] phase;

  assign step = enable && (phase == prescale);

  // Phase register: clear wins, otherwise advance or restart on a step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase <= '0;
    else if (clear)
      phase <= '0;
    else if (enable)
      phase <= step ? '0 : phase + PRESCALE_W'(1);
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with inclusive limit, wrap or saturate
// boundary handling, synchronous load and a clock-enable prescaler.
// Optional macro CNT_STICKY_OVF_EN adds ovf_sticky / ovf_clr.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH      = CNT_DEFAULT_WIDTH,
  parameter int PRESCALE_W = CNT_DEFAULT_PRESCALE_W,
  parameter int SATURATE   = MODE_WRAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  direction,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
`ifdef CNT_STICKY_OVF_EN
  input  logic                  ovf_clr,
  output logic                  ovf_sticky,
`endif
  output logic [WIDTH-1:0]      counter_out,
  output logic                  tc
);

  localparam bit HOLD_AT_BOUND = (SATURATE == MODE_SAT);

  logic             tick;
  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] count_next;

  prescaler_tick #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clear    (load),
    .prescale (prescale),
    .step     (tick)
  );

  // A load on the same edge as a due tick swallows the tick.
  assign step = tick & ~load;

  // Next count for a step and whether that step hits a boundary.
  always_comb begin
    count_next = counter_out;
    boundary   = 1'b0;
    if (direction == DIR_UP) begin
      if (counter_out < limit) begin
        count_next = counter_out + WIDTH'(1);
      end else begin
        boundary   = 1'b1;
        count_next = HOLD_AT_BOUND ? limit : '0;
      end
    end else if (counter_out > limit) begin
      // Out-of-range value (e.g. loaded above limit) snaps back into range.
      count_next = limit;
    end else if (counter_out == '0) begin
      boundary   = 1'b1;
      count_next = HOLD_AT_BOUND ? '0 : limit;
    end else begin
      count_next = counter_out - WIDTH'(1);
    end
  end

  // Count and terminal-count pulse: load > step > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_out <= '0;
      tc          <= 1'b0;
    end else if (load) begin
      counter_out <= load_value;
      tc          <= 1'b0;
    end else if (step) begin
      counter_out <= count_next;
      tc          <= boundary;
    end else begin
      tc          <= 1'b0;
    end
  end

`ifdef CNT_STICKY_OVF_EN
  // Sticky boundary flag; a boundary on the clear edge keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_sticky <= 1'b0;
    else if (step && boundary)
      ovf_sticky <= 1'b1;
    else if (ovf_clr)
      ovf_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: a wrap-mode and a saturate-mode instance
// share one directed stimulus stream; a behavioural model checks both every
// cycle and hand-computed literals pin key points. Honours CNT_STICKY_OVF_EN.
module tb_updown_counter_param;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          direction = 1'b1;
  logic          load = 1'b0;
  logic [W-1:0]  load_value = '0;
  logic [W-1:0]  limit = 8'd255;
  logic [PW-1:0] prescale = '0;
  logic          ovf_clr = 1'b0;

  logic [W-1:0]  cnt_w, cnt_s;
  logic          tc_w, tc_s;
  logic          ovf_w, ovf_s;

  int total = 0;
  int bad   = 0;

  updown_counter_param #(.WIDTH(W), .PRESCALE_W(PW), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .enable(enable), .direction(direction), .load(load),
    .load_value(load_value), .limit(limit), .prescale(prescale),
`ifdef CNT_STICKY_OVF_EN
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_w),
`endif
    .counter_out(cnt_w), .tc(tc_w)
  );

  updown_counter_param #(.WIDTH(W), .PRESCALE_W(PW), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .direction(direction), .load(load),
    .load_value(load_value), .limit(limit), .prescale(prescale),
`ifdef CNT_STICKY_OVF_EN
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_s),
`endif
    .counter_out(cnt_s), .tc(tc_s)
  );

`ifndef CNT_STICKY_OVF_EN
  assign ovf_w = 1'b0;
  assign ovf_s = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: index 0 = wrap instance, 1 = saturate instance.
  int  m_cnt[2] = '{0, 0};
  bit  m_tc[2]  = '{0, 0};
  bit  m_ovf[2] = '{0, 0};
  int  m_ph     = 0;

  initial begin
    int c, lim;
    bit stp, bnd, sat;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_ph = 0;
        for (int i = 0; i < 2; i++) begin
          m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
        end
      end else if (load) begin
        m_ph = 0;
        for (int i = 0; i < 2; i++) begin
          m_cnt[i] = int'(load_value);
          m_tc[i]  = 0;
          if (ovf_clr) m_ovf[i] = 0;
        end
      end else begin
        stp = 0;
        if (enable) begin
          if (m_ph == int'(prescale)) begin
            stp = 1; m_ph = 0;
          end else begin
            m_ph = (m_ph + 1) % (1 << PW);
          end
        end
        for (int i = 0; i < 2; i++) begin
          sat = (i == 1);
          bnd = 0;
          if (stp) begin
            c   = m_cnt[i];
            lim = int'(limit);
            if (direction) begin
              if (c < lim) c = c + 1;
              else begin bnd = 1; c = sat ? lim : 0; end
            end else if (c > lim) begin
              c = lim;
            end else if (c == 0) begin
              bnd = 1; c = sat ? 0 : lim;
            end else begin
              c = c - 1;
            end
            m_cnt[i] = c;
          end
          m_tc[i] = bnd;
          if (bnd) m_ovf[i] = 1;
          else if (ovf_clr) m_ovf[i] = 0;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("model_cnt_wrap", int'(cnt_w), m_cnt[0]);
      check("model_tc_wrap",  int'(tc_w),  int'(m_tc[0]));
      check("model_cnt_sat",  int'(cnt_s), m_cnt[1]);
      check("model_tc_sat",   int'(tc_s),  int'(m_tc[1]));
`ifdef CNT_STICKY_OVF_EN
      check("model_ovf_wrap", int'(ovf_w), int'(m_ovf[0]));
      check("model_ovf_sat",  int'(ovf_s), int'(m_ovf[1]));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus with literal expectations.
  initial begin
    int tcn_w, tcn_s;
    tick(2);
    check("reset_cnt", int'(cnt_w), 0);
    check("reset_tc", int'(tc_w), 0);
    check("reset_ovf", int'(ovf_w), 0);

    // Free count through natural binary wrap.
    rst = 1'b0; enable = 1'b1; direction = 1'b1; limit = 8'd255; prescale = '0;
    tcn_w = 0; tcn_s = 0;
    for (int k = 0; k < 258; k++) begin
      tick(1);
      tcn_w += int'(tc_w);
      tcn_s += int'(tc_s);
    end
    check("free_cnt_258", int'(cnt_w), 2);
    check("free_tc_pulses", tcn_w, 1);
    check("free_sat_cnt", int'(cnt_s), 255);
    check("free_sat_tc_pulses", tcn_s, 3);

    // Down wrap at limit 9 from a load of 2.
    limit = 8'd9; direction = 1'b0; load_value = 8'd2; load = 1'b1;
    tick(1); load = 1'b0;
    check("down_load", int'(cnt_w), 2);
    tick(1); check("down_1", int'(cnt_w), 1);
    tick(1); check("down_0", int'(cnt_w), 0);
    tick(1); check("down_wrap9", int'(cnt_w), 9);
    check("down_wrap_tc", int'(tc_w), 1);
    tick(1); check("down_8", int'(cnt_w), 8);
    check("down_8_tc", int'(tc_w), 0);
    check("down_sat_hold0", int'(cnt_s), 0);

    // Saturate at limit 5.
    limit = 8'd5; direction = 1'b1; load_value = 8'd4; load = 1'b1;
    tick(1); load = 1'b0;
    tick(4);
    check("sat_up_cnt", int'(cnt_s), 5);
    check("sat_up_tc", int'(tc_s), 1);
    check("wrap_up_cnt", int'(cnt_w), 2);
    load_value = 8'd0; load = 1'b1; direction = 1'b0;
    tick(1); load = 1'b0;
    tick(1);
    check("sat_down_cnt", int'(cnt_s), 0);
    check("sat_down_tc", int'(tc_s), 1);
    check("wrap_down_cnt", int'(cnt_w), 5);

    // Prescale by 4 with an enable gap.
    limit = 8'd255; direction = 1'b1; prescale = 4'd3; load_value = 8'd0; load = 1'b1;
    tick(1); load = 1'b0;
    tick(3); check("pre_3", int'(cnt_w), 0);
    tick(1); check("pre_4", int'(cnt_w), 1);
    tick(4); check("pre_8", int'(cnt_w), 2);
    tick(2); enable = 1'b0;
    tick(2); check("pre_frozen", int'(cnt_w), 2);
    enable = 1'b1;
    tick(1); check("pre_delay_a", int'(cnt_w), 2);
    tick(1); check("pre_delay_b", int'(cnt_w), 3);

    // Lower prescale while the phase is above it.
    load_value = 8'h10; load = 1'b1;
    tick(1); load = 1'b0;
    tick(3); prescale = 4'd1;
    tick(14); check("pre_change_wait", int'(cnt_w), 16);
    tick(1); check("pre_change_step", int'(cnt_w), 17);

    // Load beats a due step and restarts the prescaler.
    prescale = 4'd2; load_value = 8'd0; load = 1'b1;
    tick(1); load = 1'b0;
    tick(2);
    load_value = 8'h7F; load = 1'b1;
    tick(1); load = 1'b0;
    check("prio_load", int'(cnt_w), 127);
    tick(2); check("prio_ph_reset", int'(cnt_w), 127);
    tick(1); check("prio_step", int'(cnt_w), 128);

    // Asynchronous reset between edges.
    @(posedge clk); #2 rst = 1'b1; #1;
    check("async_rst_cnt", int'(cnt_w), 0);
    check("async_rst_cnt_sat", int'(cnt_s), 0);
    check("async_rst_tc", int'(tc_w), 0);
    @(negedge clk); rst = 1'b0; prescale = '0;

`ifdef CNT_STICKY_OVF_EN
    limit = 8'd255; direction = 1'b1; load_value = 8'hFE; load = 1'b1;
    tick(1); load = 1'b0;
    tick(2);
    check("ovf_set_cnt", int'(cnt_w), 0);
    check("ovf_set", int'(ovf_w), 1);
    tick(1); check("ovf_held", int'(ovf_w), 1);
    ovf_clr = 1'b1;
    tick(1); ovf_clr = 1'b0;
    check("ovf_cleared", int'(ovf_w), 0);
    check("ovf_sat_set_wins", int'(ovf_s), 1);
    load_value = 8'hFF; load = 1'b1;
    tick(1); load = 1'b0; ovf_clr = 1'b1;
    tick(1); ovf_clr = 1'b0;
    check("ovf_set_wins", int'(ovf_w), 1);
    tick(1); check("ovf_set_wins_held", int'(ovf_w), 1);
`endif

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
